// File: rtl/inert_serf_pkg.sv
// Shared constants for the inertial SPI link: register map, setup values,
// serf state encoding and a frame-building helper for the monarch side.
package inert_pkg;

  localparam int         ODR_CYCLES_DEF = 2048;
  localparam logic [7:0] WHO_AM_I_DEF   = 8'h6A;

  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_CTRL5_C   = 7'h14;
  localparam logic [6:0] ADDR_OUTZ_L_G  = 7'h26;
  localparam logic [6:0] ADDR_OUTZ_H_G  = 7'h27;

  localparam logic [7:0] SETUP_INT1_CTRL = 8'h02;
  localparam logic [7:0] SETUP_CTRL2_G   = 8'h60;
  localparam logic [7:0] SETUP_CTRL5_C   = 8'h40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } serf_state_e;

  // 16-bit frame: R/W in bit 15, address in 14:8, write data in 7:0
  function automatic logic [15:0] spi_cmd(input logic rd, input logic [6:0] addr,
                                          input logic [7:0] data);
    return {rd, addr, data};
  endfunction

endpackage

// File: rtl/inert_serf_if.sv
// SPI pins between the inertial interface (monarch) and the sensor serf.
interface inert_serf_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_serf_phy.sv
// SPI serf physical layer: pin synchronizers, SCLK edge detect, frame FSM,
// bit counter and the rx/tx shift registers.
module spi_serf_phy
  import inert_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ss_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        addr_vld,
  output logic        addr_rd,
  output logic [6:0]  addr,
  input  logic        load,
  input  logic [7:0]  load_data,
  output logic        frame_end,
  output logic        frame_ok,
  output logic        idle,
  output logic [15:0] rx_word
);

  logic        ss_n_meta_r, ss_n_sync_r, ss_n_prev_r;
  logic        sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic        mosi_meta_r, mosi_sync_r;
  serf_state_e state_r, state_s;
  logic [4:0]  bit_cnt_r;
  logic [15:0] rx_r;
  logic [7:0]  tx_r;
  logic        sclk_rise_s, sclk_fall_s, ss_fall_s, shift_st_s, tx_shift_s;

  // SS_n flops reset low so a high pin after reset reads as a rise, never a
  // fall: a frame cut by reset is skipped until the next genuine SS_n fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_n_meta_r <= 1'b0;
      ss_n_sync_r <= 1'b0;
      ss_n_prev_r <= 1'b0;
      sclk_meta_r <= 1'b1;
      sclk_sync_r <= 1'b1;
      sclk_prev_r <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      ss_n_meta_r <= ss_n;
      ss_n_sync_r <= ss_n_meta_r;
      ss_n_prev_r <= ss_n_sync_r;
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      mosi_meta_r <= mosi;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
  assign ss_fall_s   = ss_n_prev_r & ~ss_n_sync_r;
  assign shift_st_s  = (state_r == SHIFT);
  // Fall n follows rise n-1; falls 10..16 walk bits 6..0 onto MISO
  assign tx_shift_s  = shift_st_s && sclk_fall_s &&
                       (bit_cnt_r >= 5'd9) && (bit_cnt_r <= 5'd15);

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ss_fall_s) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (ss_n_sync_r) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Rise counter saturates at 17 so over-long frames still read as aborted
  always_ff @(posedge clk) begin
    if (rst || (state_r == IDLE)) begin
      bit_cnt_r <= 5'd0;
    end else if (shift_st_s && sclk_rise_s && (bit_cnt_r != 5'd17)) begin
      bit_cnt_r <= bit_cnt_r + 5'd1;
    end
  end

  // MOSI capture, MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_r <= 16'h0000;
    end else if (shift_st_s && sclk_rise_s) begin
      rx_r <= {rx_r[14:0], mosi_sync_r};
    end
  end

  // Read data: loaded on the 8th rise, shifted on falls, held at 0 in IDLE
  always_ff @(posedge clk) begin
    if (rst || (state_s == IDLE)) begin
      tx_r <= 8'h00;
    end else if (load) begin
      tx_r <= load_data;
    end else if (tx_shift_s) begin
      tx_r <= {tx_r[6:0], 1'b0};
    end
  end

  // On the 8th rise the address LSB is still on the synchronized MOSI
  assign addr_vld  = shift_st_s && sclk_rise_s && (bit_cnt_r == 5'd7);
  assign addr_rd   = rx_r[6];
  assign addr      = {rx_r[5:0], mosi_sync_r};
  assign frame_end = (state_r == DONE);
  assign frame_ok  = frame_end && (bit_cnt_r == 5'd16);
  assign idle      = (state_r == IDLE);
  assign rx_word   = rx_r;
  assign miso      = tx_r[7];

endmodule

// File: rtl/inert_serf.sv
// Inertial sensor serf: register file, OUTZ low/high shadow, ODR sample timer
// and sample-ready interrupt on top of the SPI serf PHY.
module inert_serf
  import inert_pkg::*;
#(
  parameter int         ODR_CYCLES   = ODR_CYCLES_DEF,
  parameter logic [7:0] WHO_AM_I_VAL = WHO_AM_I_DEF
) (
  input  logic               clk,
  input  logic               rst,
  inert_serf_if.slave        spi,
  output logic               INT,
  input  logic signed [15:0] yaw_in,
  output logic               nemo_setup
);

  localparam int              ODR_W    = (ODR_CYCLES > 1) ? $clog2(ODR_CYCLES) : 1;
  localparam logic [ODR_W-1:0] ODR_LAST = ODR_W'(ODR_CYCLES - 1);

  logic        addr_vld_s, addr_rd_s, frame_end_s, frame_ok_s, idle_s;
  logic [6:0]  addr_s;
  logic [15:0] rx_word_s;
  logic [7:0]  rd_data_s;

  logic [7:0]  int1_ctrl_r, ctrl2_g_r, ctrl5_c_r;
  logic [7:0]  outz_l_r, outz_h_r, shadow_r;
  logic        shadow_vld_r;
  logic [ODR_W-1:0] odr_cnt_r;
  logic        sample_pend_r, int_r, nemo_setup_r;

  logic        wr_en_s, int_clr_s, odr_run_s, odr_tc_s, apply_s;
  logic        rd_outz_l_s, rd_outz_h_s;

  spi_serf_phy u_phy (
    .clk       (clk),
    .rst       (rst),
    .ss_n      (spi.SS_n),
    .sclk      (spi.SCLK),
    .mosi      (spi.MOSI),
    .miso      (spi.MISO),
    .addr_vld  (addr_vld_s),
    .addr_rd   (addr_rd_s),
    .addr      (addr_s),
    .load      (addr_vld_s),
    .load_data (rd_data_s),
    .frame_end (frame_end_s),
    .frame_ok  (frame_ok_s),
    .idle      (idle_s),
    .rx_word   (rx_word_s)
  );

  assign wr_en_s     = frame_ok_s && !rx_word_s[15];
  assign int_clr_s   = frame_ok_s && rx_word_s[15] && (rx_word_s[14:8] == ADDR_OUTZ_H_G);
  assign rd_outz_l_s = addr_vld_s && addr_rd_s && (addr_s == ADDR_OUTZ_L_G);
  assign rd_outz_h_s = addr_vld_s && addr_rd_s && (addr_s == ADDR_OUTZ_H_G);
  assign odr_run_s   = (ctrl2_g_r != 8'h00);
  assign odr_tc_s    = odr_run_s && (odr_cnt_r == ODR_LAST);
  // Samples only land between frames so a read never sees a torn update
  assign apply_s     = sample_pend_r && idle_s;

  // Register read mux, sampled into the tx shifter on the 8th rise
  always_comb begin
    rd_data_s = 8'h00;
    case (addr_s)
      ADDR_INT1_CTRL: rd_data_s = int1_ctrl_r;
      ADDR_WHO_AM_I:  rd_data_s = WHO_AM_I_VAL;
      ADDR_CTRL2_G:   rd_data_s = ctrl2_g_r;
      ADDR_CTRL5_C:   rd_data_s = ctrl5_c_r;
      ADDR_OUTZ_L_G:  rd_data_s = outz_l_r;
      ADDR_OUTZ_H_G: begin
        if (shadow_vld_r) begin
          rd_data_s = shadow_r;
        end else begin
          rd_data_s = outz_h_r;
        end
      end
      default:        rd_data_s = 8'h00;
    endcase
  end

  // Control registers, written only by complete 16-bit write frames
  always_ff @(posedge clk) begin
    if (rst) begin
      int1_ctrl_r <= 8'h00;
      ctrl2_g_r   <= 8'h00;
      ctrl5_c_r   <= 8'h00;
    end else if (wr_en_s) begin
      case (rx_word_s[14:8])
        ADDR_INT1_CTRL: int1_ctrl_r <= rx_word_s[7:0];
        ADDR_CTRL2_G:   ctrl2_g_r   <= rx_word_s[7:0];
        ADDR_CTRL5_C:   ctrl5_c_r   <= rx_word_s[7:0];
        default: begin
        end
      endcase
    end
  end

  // Reading OUTZ_L freezes OUTZ_H so the following high-byte read matches it
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r     <= 8'h00;
      shadow_vld_r <= 1'b0;
    end else if (rd_outz_l_s) begin
      shadow_r     <= outz_h_r;
      shadow_vld_r <= 1'b1;
    end else if (rd_outz_h_s || (frame_end_s && !frame_ok_s)) begin
      shadow_vld_r <= 1'b0;
    end
  end

  // Free-running ODR timer, paused while the gyro is powered down
  always_ff @(posedge clk) begin
    if (rst) begin
      odr_cnt_r <= '0;
    end else if (odr_tc_s) begin
      odr_cnt_r <= '0;
    end else if (odr_run_s) begin
      odr_cnt_r <= odr_cnt_r + 1'b1;
    end
  end

  // Pending-sample flag and output data latch
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_pend_r <= 1'b0;
      outz_l_r      <= 8'h00;
      outz_h_r      <= 8'h00;
    end else begin
      if (odr_tc_s) begin
        sample_pend_r <= 1'b1;
      end else if (apply_s) begin
        sample_pend_r <= 1'b0;
      end
      if (apply_s) begin
        {outz_h_r, outz_l_r} <= yaw_in;
      end
    end
  end

  // INT set on sample apply (IDLE) and cleared in DONE; the two never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      int_r <= 1'b0;
    end else if (apply_s && int1_ctrl_r[1]) begin
      int_r <= 1'b1;
    end else if (int_clr_s) begin
      int_r <= 1'b0;
    end
  end

  // Setup-complete indicator
  always_ff @(posedge clk) begin
    if (rst) begin
      nemo_setup_r <= 1'b0;
    end else begin
      nemo_setup_r <= (int1_ctrl_r == SETUP_INT1_CTRL) &&
                      (ctrl2_g_r == SETUP_CTRL2_G) &&
                      (ctrl5_c_r == SETUP_CTRL5_C);
    end
  end

  assign INT        = int_r;
  assign nemo_setup = nemo_setup_r;

endmodule

// File: tb/tb_inert_serf.sv
// Self-checking bench for inert_serf: a monarch task drives SPI frames and
// queues expected read bytes; a monitor pops and compares each completed read.
module tb_inert_serf;
  import inert_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq;
  logic        nemo_setup;
  logic [15:0] yaw_in;

  inert_serf_if spi_if ();

  inert_serf dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi_if),
    .INT        (irq),
    .yaw_in     (yaw_in),
    .nemo_setup (nemo_setup)
  );

  always #10 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          rd_idx = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_byte;
  logic [7:0]  mon_exp;
  event        rd_ev;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed read frame is compared with the oldest expectation
  initial begin
    forever begin
      @(rd_ev);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd[%0d]: got %h with no expected value queued", rd_idx, obs_byte);
      end else begin
        mon_exp = exp_q.pop_front();
        if (obs_byte !== mon_exp) begin
          errors++;
          $display("FAIL rd[%0d]: got %h expected %h", rd_idx, obs_byte, mon_exp);
        end
      end
      rd_idx++;
    end
  end

  // One SPI frame of nrise clocks; rst pulses mid-high-half after rise rst_rise
  task automatic spi_frame(input logic [15:0] word, input int nrise, input int rst_rise,
                           output logic [7:0] rd, output logic int_post);
    rd = 8'h00;
    @(negedge clk);
    spi_if.SS_n = 1'b0;
    repeat (16) @(negedge clk);
    for (int k = 0; k < nrise; k++) begin
      spi_if.SCLK = 1'b0;
      spi_if.MOSI = word[15 - k];
      repeat (16) @(negedge clk);
      if (k >= 8) rd = {rd[6:0], spi_if.MISO};
      spi_if.SCLK = 1'b1;
      if (k + 1 == rst_rise) begin
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_miso", 16'(spi_if.MISO), 16'd0);
        chk("rst_mid_int", 16'(irq), 16'd0);
        chk("rst_mid_setup", 16'(nemo_setup), 16'd0);
        rst = 1'b0;
        repeat (7) @(negedge clk);
      end else begin
        repeat (16) @(negedge clk);
      end
    end
    spi_if.SS_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 int_post = irq;
    repeat (16) @(negedge clk);
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    logic [7:0] rd;
    logic       ip;
    spi_frame(spi_cmd(1'b0, addr, data), 16, 0, rd, ip);
  endtask

  task automatic spi_read(input logic [6:0] addr, input logic [7:0] exp, output logic int_post);
    logic [7:0] rd;
    exp_q.push_back(exp);
    spi_frame(spi_cmd(1'b1, addr, 8'h00), 16, 0, rd, int_post);
    obs_byte = rd;
    ->rd_ev;
  endtask

  task automatic wait_int(input string name);
    int n = 0;
    while (irq !== 1'b1 && n < 2 * ODR_CYCLES_DEF + 64) begin
      @(negedge clk);
      n++;
    end
    chk(name, 16'(irq), 16'd1);
  endtask

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ip;
    logic [7:0] rd;
    spi_if.SS_n = 1'b1;
    spi_if.SCLK = 1'b1;
    spi_if.MOSI = 1'b0;
    rst         = 1'b1;
    yaw_in      = 16'hFF85;
    repeat (4) @(negedge clk);
    chk("reset_miso", 16'(spi_if.MISO), 16'd0);
    chk("reset_int", 16'(irq), 16'd0);
    chk("reset_setup", 16'(nemo_setup), 16'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Configuration writes and read-back
    spi_write(ADDR_INT1_CTRL, 8'h02);
    spi_write(ADDR_CTRL2_G, 8'h60);
    chk("setup_partial", 16'(nemo_setup), 16'd0);
    spi_write(ADDR_CTRL5_C, 8'h40);
    repeat (2) @(negedge clk);
    chk("setup_done", 16'(nemo_setup), 16'd1);
    spi_read(ADDR_INT1_CTRL, 8'h02, ip);
    spi_read(ADDR_WHO_AM_I, 8'h6A, ip);
    chk("whoami_int", 16'(ip), 16'd0);

    // First sample, coherent low/high read, INT clear
    wait_int("int_sample1");
    spi_read(ADDR_OUTZ_L_G, 8'h85, ip);
    chk("int_after_outz_l", 16'(ip), 16'd1);
    spi_read(ADDR_OUTZ_H_G, 8'hFF, ip);
    chk("int_clear", 16'(ip), 16'd0);

    // Sample lands between low and high reads: high byte comes from the shadow
    spi_read(ADDR_OUTZ_L_G, 8'h85, ip);
    yaw_in = 16'h1234;
    wait_int("int_sample2");
    spi_read(ADDR_OUTZ_H_G, 8'hFF, ip);
    spi_read(ADDR_OUTZ_L_G, 8'h34, ip);
    spi_read(ADDR_OUTZ_H_G, 8'h12, ip);

    // Aborted write after 9 rises is discarded
    spi_frame(spi_cmd(1'b0, ADDR_INT1_CTRL, 8'h00), 9, 0, rd, ip);
    chk("abort_setup", 16'(nemo_setup), 16'd1);
    spi_read(ADDR_INT1_CTRL, 8'h02, ip);

    // Unmapped address: write ignored, reads zero
    spi_write(7'h2A, 8'h55);
    spi_read(7'h2A, 8'h00, ip);

    // Reset in the middle of a WHO_AM_I read, then recovery
    wait_int("int_before_rst");
    spi_frame(spi_cmd(1'b1, ADDR_WHO_AM_I, 8'h00), 16, 11, rd, ip);
    spi_read(ADDR_WHO_AM_I, 8'h6A, ip);
    chk("int_after_rst", 16'(ip), 16'd0);
    spi_read(ADDR_INT1_CTRL, 8'h00, ip);
    chk("setup_after_rst", 16'(nemo_setup), 16'd0);

    repeat (4) @(negedge clk);
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inert_serf.md
# inert_serf

Synthesizable SPI serf model of the ST 6-axis inertial sensor, used as the far end of the gyro SPI link in full-chip benches and on the FPGA loopback build. It answers the configuration writes and yaw-rate reads issued by the inertial interface, supplies 16-bit yaw samples at a fixed output data rate, and raises INT when a fresh sample is ready. Only the registers the robot uses are modelled.

## Interface
- ODR_CYCLES, 2048: clk cycles between new yaw samples.
- WHO_AM_I_VAL, 8'h6A: value read back from address 0x0F.
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- SS_n  in  1  serf select, active low, asynchronous to clk
- SCLK  in  1  SPI clock, idles high, asynchronous to clk
- MOSI  in  1  serial data from monarch
- MISO  out  1  serial data to monarch; reset 0
- INT  out  1  sample-ready interrupt; reset 0
- yaw_in  in  16  signed yaw rate the bench wants reported next
- nemo_setup  out  1  high while INT1_CTRL==8'h02, CTRL2_G==8'h60 and CTRL5_C==8'h40; reset 0

## Operation
- SS_n, SCLK and MOSI each pass through two synchronizer flops. A third flop on SCLK provides rise/fall detection.
- Frame format: 16 bits, MSB first. Bit 15 is R/W (1 = read), bits 14:8 are addr[6:0], and bits 7:0 are write data (don't-care on reads).
- MOSI is sampled on each detected SCLK rise into a 16-bit rx shift register.
- State machine:
  - IDLE: waits for the synced SS_n to fall, clears the bit counter, then goes to SHIFT.
  - SHIFT: counts SCLK rises 0..16. When the synced SS_n rises, it goes to DONE.
  - DONE (1 cycle): commits the frame, then goes to IDLE.
- Read path: on the 8th rise, load the tx shift register with the register at addr. MISO = tx[7]. Shift left on falls 10 through 16. MISO is 0 whenever the state is IDLE.
- Register map:
  - 0x0D INT1_CTRL: R/W
  - 0x11 CTRL2_G: R/W
  - 0x14 CTRL5_C: R/W
  - 0x0F WHO_AM_I: read only
  - 0x26 OUTZ_L_G: read only
  - 0x27 OUTZ_H_G: read only
  - Unmapped addresses read 8'h00; writes to them are ignored.
- Reading 0x26 snapshots the high byte into a shadow register. A later read of 0x27 returns the shadow if one is pending. This keeps low/high pairs coherent.
- Writes commit in DONE, and only if exactly 16 rises were counted and bit 15 is 0.
- ODR timer: a free-running counter of width $clog2(ODR_CYCLES). It only runs while CTRL2_G != 0. At terminal count it raises sample_pend.
- Applying sample_pend: applied in IDLE (never mid-frame). It loads yaw_in into OUTZ_H/L and sets INT if INT1_CTRL[1] is 1.
- Clearing INT: INT clears in DONE after a complete 16-bit read of 0x27.

## Timing
- Pin-to-detect latency is 3 clk. SPI_mnrch's SCLK is clk/32, so each half-period has 16 clk of margin.
- MISO changes 1 clk after a detected fall, or after the 8th detected rise.
- Write commit and INT clear occur 1 clk after synced SS_n rises, i.e. 3 clk after the pin.
- INT rises 1 clk after a sample is applied.
- Aborted frame (SS_n rises with fewer or more than 16 rises): no write, no INT clear, shadow invalidated. The block returns to IDLE.
- Sample arriving while INT is already high: data is overwritten and INT stays high.
- Sample arriving during SHIFT: held pending, and applied on the first IDLE cycle.
- Simultaneous INT clear in DONE and a pending sample: the clear happens in DONE, then the sample is applied in the following IDLE cycle, so INT drops for exactly 1 cycle.
- rst mid-frame: state goes to IDLE. All registers reset to 0, except WHO_AM_I. The ODR counter and sample_pend clear; MISO=0 and INT=0 on the next edge. The partial frame is discarded, and the block resyncs on the next SS_n fall.

## Structure
- Package inert_pkg holds:
  - register address localparams (ADDR_INT1_CTRL etc.)
  - expected setup values 8'h02, 8'h60, 8'h40
  - the serf state enum {IDLE, SHIFT, DONE}
- The inertial interface imports the same package for its command constants.
- One sub-module, spi_serf_phy, owns synchronizers, edge detect, bit counter, and rx/tx shift registers. It exposes:
  - addr_vld and addr
  - load and load_data
  - frame_ok, which pulses in DONE
  - rx_word
- The register file, shadow, ODR timer and INT logic stay in the top module.

## Test plan
- Reset, then write 16'h0D02, 16'h1160, 16'h1440 -> nemo_setup=1 after the third frame; reading 16'h8Dxx returns 8'h02.
- Read 16'h8Fxx -> MISO shifts 8'h6A on bits 7:0; INT unchanged.
- After setup, yaw_in=16'hFF85 and wait ODR_CYCLES -> INT=1. Read 0x26 then 0x27 -> 8'h85 then 8'hFF, and INT=0 3 clk after SS_n rises.
- Change yaw_in to 16'h1234 between the 0x26 and 0x27 reads while a sample lands -> 0x27 still returns 8'hFF (shadow). The next pair returns 8'h34, 8'h12.
- Raise SS_n after 9 rises of a 16'h0D00 write -> INT1_CTRL stays 8'h02 and nemo_setup stays 1.
- Assert rst for 1 clk mid-read -> MISO=0, INT=0, nemo_setup=0. The next full 0x0F read still returns 8'h6A.
